truth_table_capture: RTL

//  Characterises an unknown 3-input combinational gate by driving all 8 input

---
 rtl/tt_pkg.sv | 8 +
 rtl/tt_vote_acc.sv | 27 ++
 rtl/truth_table_capture.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding, vector count and bit-position helper for truth-table capture
package tt_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT_GAP, COMMIT, DONE} tt_state_e;
  localparam int TT_NUM_VECTORS = 8;
  function automatic logic [2:0] tt_bit_pos(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction
endpackage

// File: rtl/tt_vote_acc.sv
// tt_vote_acc: counts ones over the samples of one vector and reports majority and disagreement
module tt_vote_acc #(
  parameter int NUM_SAMPLES = 3,
  localparam int CW = $clog2(NUM_SAMPLES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample_en,
  input  logic          out,
  output logic [CW-1:0] ones_count,
  output logic          majority,
  output logic          disagree
);
  localparam logic [CW-1:0] HALF = CW'(NUM_SAMPLES / 2);
  localparam logic [CW-1:0] ALL = CW'(NUM_SAMPLES);
  logic [CW-1:0] ones_q, ones_d;
  // clear wins over a sample taken in the same cycle
  always_comb ones_d = clear ? '0 : ones_q + CW'(sample_en & out);
  // ones counter register
  always_ff @(posedge clk)
    if (rst) ones_q <= '0;
    else ones_q <= ones_d;
  assign ones_count = ones_q;
  assign majority = ones_q > HALF;
  assign disagree = ones_q != '0 && ones_q != ALL;
endmodule

// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps all 8 input vectors of a 3-input gate and records its truth-table code
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES = 3,
  parameter int SAMPLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic [7:0] unstable
);
  localparam int CW = $clog2(NUM_SAMPLES) + 1;
  localparam int TMAX = SETTLE_CYCLES > SAMPLE_GAP ? SETTLE_CYCLES : SAMPLE_GAP;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(SAMPLE_GAP > 1 ? SAMPLE_GAP - 2 : 0);
  localparam logic [CW-1:0] SMP_LAST = CW'(NUM_SAMPLES - 1);
  tt_state_e     state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] smp_q, smp_d;
  logic [7:0]    scr_code_q, scr_code_d, scr_unst_q, scr_unst_d;
  logic [7:0]    code_q, code_d, unst_q, unst_d;
  logic          vote_clr, sample_en, majority, disagree;
  logic [CW-1:0] vote_ones_unused;
  tt_vote_acc #(.NUM_SAMPLES(NUM_SAMPLES)) u_vote (
    .clk       (clk),
    .rst       (rst),
    .clear     (vote_clr),
    .sample_en (sample_en),
    .out       (out),
    .ones_count(vote_ones_unused),
    .majority  (majority),
    .disagree  (disagree)
  );
  // next-state logic; abort overrides every transition and freezes the published result
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    tmr_d = tmr_q;
    smp_d = smp_q;
    scr_code_d = scr_code_q;
    scr_unst_d = scr_unst_q;
    code_d = code_q;
    unst_d = unst_q;
    vote_clr = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        idx_d = '0;
        tmr_d = '0;
        smp_d = '0;
        scr_code_d = '0;
        scr_unst_d = '0;
        vote_clr = 1'b1;
      end
      SETTLE: begin
        tmr_d = tmr_q == SETTLE_LAST ? '0 : tmr_q + TW'(1);
        state_d = tmr_q == SETTLE_LAST ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        sample_en = 1'b1;
        smp_d = smp_q + CW'(1);
        tmr_d = '0;
        state_d = smp_q == SMP_LAST ? COMMIT : SAMPLE_GAP > 1 ? WAIT_GAP : SAMPLE;
      end
      WAIT_GAP: begin
        tmr_d = tmr_q + TW'(1);
        state_d = tmr_q == GAP_LAST ? SAMPLE : WAIT_GAP;
      end
      COMMIT: begin
        scr_code_d[tt_bit_pos(idx_q)] = majority;
        scr_unst_d[tt_bit_pos(idx_q)] = disagree;
        vote_clr = 1'b1;
        smp_d = '0;
        tmr_d = '0;
        state_d = idx_q == 3'd7 ? DONE : SETTLE;
        idx_d = idx_q == 3'd7 ? idx_q : idx_q + 3'd1;
        code_d = idx_q == 3'd7 ? scr_code_d : code_q;
        unst_d = idx_q == 3'd7 ? scr_unst_d : unst_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      code_d = code_q;
      unst_d = unst_q;
    end
  end
  // state, timers and result registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      tmr_q <= '0;
      smp_q <= '0;
      scr_code_q <= '0;
      scr_unst_q <= '0;
      code_q <= '0;
      unst_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      tmr_q <= tmr_d;
      smp_q <= smp_d;
      scr_code_q <= scr_code_d;
      scr_unst_q <= scr_unst_d;
      code_q <= code_d;
      unst_q <= unst_d;
    end
  // outputs decode from state; the gate inputs only carry idx while a vector is in flight
  always_comb begin
    busy = state_q inside {SETTLE, SAMPLE, WAIT_GAP, COMMIT};
    done = state_q == DONE;
    {in1, in2, in3} = busy ? idx_q : 3'b000;
    code = code_q;
    unstable = unst_q;
  end
endmodule
